// File: rtl/tsc_pkg.sv
// Shared types and constants for the totally-self-checking checker self-test controller.
package tsc_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FUNC     = 3'd1,
    ST_TEST     = 3'd2,
    ST_RECONFIG = 3'd3,
    ST_FAULT    = 3'd4
  } tsc_state_e;

  // Test codewords, bit order {x0, y0, x1, y1}; each bit expands to a full rail word.
  localparam logic [3:0] TV0 = 4'b0101;
  localparam logic [3:0] TV1 = 4'b0110;
  localparam logic [3:0] TV2 = 4'b1001;
  localparam logic [3:0] TV3 = 4'b1010;

  function automatic logic [3:0] tsc_test_vec(input logic [1:0] idx);
    case (idx)
      2'd0:    return TV0;
      2'd1:    return TV1;
      2'd2:    return TV2;
      default: return TV3;
    endcase
  endfunction

endpackage

// File: rtl/tsc_cw_detect.sv
// Two-rail codeword detector: valid only when every rail bit pair is complementary.
module tsc_cw_detect
  import tsc_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_valid
);

  assign o_valid = &(i_x ^ i_y);

endmodule

// File: rtl/tsc_selftest_ctrl.sv
// Self-test controller: drives functional or test codewords into a two-rail checker,
// checks each response one cycle later, and reconfigures or latches a fault on errors.
module tsc_selftest_ctrl
  import tsc_pkg::*;
#(
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned TEST_PERIOD = 256,
  parameter int unsigned ERR_THRESH  = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         func_valid,
  output logic         func_ready,
  input  logic [W-1:0] func_x0,
  input  logic [W-1:0] func_y0,
  input  logic [W-1:0] func_x1,
  input  logic [W-1:0] func_y1,
  output logic [W-1:0] chk_x0,
  output logic [W-1:0] chk_y0,
  output logic [W-1:0] chk_x1,
  output logic [W-1:0] chk_y1,
  input  logic [W-1:0] chk_final_x,
  input  logic [W-1:0] chk_final_y,
  output logic         logic_en,
  output logic         test_active,
  output logic         err_pulse,
  output logic [7:0]   err_count,
  output logic         fault
);

  localparam int unsigned PW = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;

  tsc_state_e   r_state, w_state_n;
  logic [PW-1:0] r_period;
  logic [7:0]   r_consec, w_consec_next;
  logic [2:0]   r_tidx;
  logic         r_tfail, r_from_rc;
  logic         r_pend, r_pend_func;
  logic [W-1:0] r_chk_x0, r_chk_y0, r_chk_x1, r_chk_y1;
  logic         r_logic_en, r_err_pulse;
  logic [7:0]   r_err_count;
  logic         w_resp_valid, w_err, w_test_fail;
  logic [3:0]   w_vec;

  tsc_cw_detect #(.W(W)) u_cw_detect (
    .i_x     (chk_final_x),
    .i_y     (chk_final_y),
    .o_valid (w_resp_valid)
  );

  assign func_ready  = (r_state == ST_FUNC) && enable;
  assign test_active = (r_state == ST_TEST);
  assign fault       = (r_state == ST_FAULT);
  assign chk_x0      = r_chk_x0;
  assign chk_y0      = r_chk_y0;
  assign chk_x1      = r_chk_x1;
  assign chk_y1      = r_chk_y1;
  assign logic_en    = r_logic_en;
  assign err_pulse   = r_err_pulse;
  assign err_count   = r_err_count;

  assign w_err       = r_pend && !w_resp_valid;
  assign w_test_fail = r_tfail || (w_err && !r_pend_func);
  assign w_vec       = tsc_test_vec(r_tidx[1:0]);

  always_comb begin
    w_consec_next = r_consec;
    if (r_pend && r_pend_func) begin
      if (!w_resp_valid) begin
        if (r_consec != 8'hFF) w_consec_next = r_consec + 8'd1;
      end else begin
        w_consec_next = '0;
      end
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:     if (enable) w_state_n = ST_FUNC;
      ST_FUNC: begin
        // Error threshold wins over both disable and period expiry.
        if (w_consec_next >= 8'(ERR_THRESH))       w_state_n = ST_RECONFIG;
        else if (!enable)                          w_state_n = ST_IDLE;
        else if (r_period == PW'(TEST_PERIOD - 1)) w_state_n = ST_TEST;
      end
      ST_TEST: begin
        if (r_tidx == 3'd4) begin
          if (w_test_fail) w_state_n = r_from_rc ? ST_FAULT : ST_RECONFIG;
          else             w_state_n = enable ? ST_FUNC : ST_IDLE;
        end
      end
      ST_RECONFIG: w_state_n = ST_TEST;
      ST_FAULT:    w_state_n = ST_FAULT;
      default:     w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_period    <= '0;
      r_consec    <= '0;
      r_tidx      <= '0;
      r_tfail     <= 1'b0;
      r_from_rc   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_func <= 1'b0;
      r_chk_x0    <= '0;
      r_chk_y0    <= '0;
      r_chk_x1    <= '0;
      r_chk_y1    <= '0;
      r_logic_en  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_n;
      r_err_pulse <= w_err;
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      r_consec    <= (r_state == ST_RECONFIG) ? '0 : w_consec_next;
      r_pend      <= 1'b0;
      r_pend_func <= 1'b0;
      case (r_state)
        ST_IDLE: r_period <= '0;
        ST_FUNC: begin
          if (func_ready && func_valid) begin
            r_chk_x0    <= func_x0;
            r_chk_y0    <= func_y0;
            r_chk_x1    <= func_x1;
            r_chk_y1    <= func_y1;
            r_pend      <= 1'b1;
            r_pend_func <= 1'b1;
          end
          if (w_state_n == ST_TEST) begin
            r_period  <= '0;
            r_tidx    <= '0;
            r_tfail   <= 1'b0;
            r_from_rc <= 1'b0;
          end else if (w_state_n == ST_FUNC) begin
            r_period <= r_period + PW'(1);
          end
        end
        ST_TEST: begin
          if (r_tidx != 3'd4) begin
            r_chk_x0 <= {W{w_vec[3]}};
            r_chk_y0 <= {W{w_vec[2]}};
            r_chk_x1 <= {W{w_vec[1]}};
            r_chk_y1 <= {W{w_vec[0]}};
            r_pend   <= 1'b1;
          end
          r_tidx  <= r_tidx + 3'd1;
          r_tfail <= w_test_fail;
        end
        ST_RECONFIG: begin
          r_logic_en <= ~r_logic_en;
          r_period   <= '0;
          r_tidx     <= '0;
          r_tfail    <= 1'b0;
          r_from_rc  <= 1'b1;
        end
        default: ;
      endcase
      if ((w_state_n == ST_IDLE) || (w_state_n == ST_FAULT)) begin
        r_chk_x0 <= '0;
        r_chk_y0 <= '0;
        r_chk_x1 <= '0;
        r_chk_y1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tsc_selftest_ctrl.sv
// Directed bench for tsc_selftest_ctrl with a behavioural two-rail checker and fault injection.
module tb_tsc_selftest_ctrl;

  localparam int unsigned W = 16;

  logic         clk, rst_n, enable, func_valid, func_ready;
  logic [W-1:0] func_x0, func_y0, func_x1, func_y1;
  logic [W-1:0] chk_x0, chk_y0, chk_x1, chk_y1;
  logic [W-1:0] chk_final_x, chk_final_y;
  logic         logic_en, test_active, err_pulse, fault;
  logic [7:0]   err_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int mode    = 0;

  tsc_selftest_ctrl #(.W(W), .TEST_PERIOD(8), .ERR_THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .func_valid(func_valid), .func_ready(func_ready),
    .func_x0(func_x0), .func_y0(func_y0), .func_x1(func_x1), .func_y1(func_y1),
    .chk_x0(chk_x0), .chk_y0(chk_y0), .chk_x1(chk_x1), .chk_y1(chk_y1),
    .chk_final_x(chk_final_x), .chk_final_y(chk_final_y),
    .logic_en(logic_en), .test_active(test_active), .err_pulse(err_pulse),
    .err_count(err_count), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Healthy two-rail checker; modes inject faults: 1 all-0 while logic_en=0,
  // 2 all-0 on vector 1001 while logic_en=0, 3 all-0 always, 4 all-0 on vector 0110.
  logic [W-1:0] w_fx, w_fy;
  logic         w_bad;
  logic [63:0]  w_chk64;
  assign w_fx    = (chk_x0 & chk_x1) | (chk_y0 & chk_y1);
  assign w_fy    = (chk_x0 & chk_y1) | (chk_y0 & chk_x1);
  assign w_chk64 = {chk_x0, chk_y0, chk_x1, chk_y1};
  assign w_bad   = (mode == 1 && !logic_en) || (mode == 3) ||
                   (mode == 2 && !logic_en && w_chk64 == vecw(4'b1001)) ||
                   (mode == 4 && w_chk64 == vecw(4'b0110));
  assign chk_final_x = w_bad ? '0 : w_fx;
  assign chk_final_y = w_bad ? '0 : w_fy;

  function automatic logic [63:0] vecw(input logic [3:0] v);
    return {{16{v[3]}}, {16{v[2]}}, {16{v[1]}}, {16{v[0]}}};
  endfunction

  function automatic logic [63:0] opw(input int i);
    logic [15:0] a, b;
    a = 16'hA5A0 + 16'(i);
    b = 16'h3C30 + 16'(i);
    return {a, ~a, b, ~b};
  endfunction

  task automatic set_op(input int i);
    logic [63:0] o;
    o = opw(i);
    {func_x0, func_y0, func_x1, func_y1} = o;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; func_valid = 1'b0; set_op(0);
    tick(); tick();
    // Reset state
    check("rst_func_ready", 64'(func_ready), 64'd0);
    check("rst_test_active", 64'(test_active), 64'd0);
    check("rst_err", 64'({err_pulse, fault, logic_en}), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_chk", w_chk64, 64'd0);
    rst_n = 1'b1;

    // Healthy run: 8 FUNC cycles then 4 test vectors, back to FUNC
    tick();
    enable = 1'b1; func_valid = 1'b1; set_op(0);
    tick();
    check("a_ready_c0", 64'(func_ready), 64'd1);
    check("a_chk_idle", w_chk64, 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("a_chk_op", w_chk64, opw(i - 1));
      check("a_not_test", 64'(test_active), 64'd0);
      set_op(i);
    end
    tick();
    check("a_test_entry", 64'({test_active, func_ready}), 64'b10);
    check("a_last_op", w_chk64, opw(7));
    tick(); check("a_vec0", w_chk64, vecw(4'b0101));
    tick(); check("a_vec1", w_chk64, vecw(4'b0110));
    tick(); check("a_vec2", w_chk64, vecw(4'b1001));
    tick(); check("a_vec3", w_chk64, vecw(4'b1010));
    check("a_still_test", 64'(test_active), 64'd1);
    tick();
    check("a_back_func", 64'({test_active, func_ready}), 64'b01);
    check("a_err_count", 64'(err_count), 64'd0);

    // Three consecutive bad functional responses -> RECONFIG
    rst_n = 1'b0; enable = 1'b0; func_valid = 1'b0; mode = 1;
    tick(); rst_n = 1'b1; enable = 1'b1;
    tick();
    func_valid = 1'b1; set_op(3);
    tick(); check("b_pulse0", 64'(err_pulse), 64'd0);
    tick(); check("b_pulse1", 64'({err_pulse, err_count}), {55'd0, 1'b1, 8'd1});
    tick(); check("b_pulse2", 64'({err_pulse, err_count}), {55'd0, 1'b1, 8'd2});
    func_valid = 1'b0;
    tick();
    check("b_reconfig", 64'({err_pulse, test_active, func_ready, logic_en}), 64'b1000);
    check("b_err_count3", 64'(err_count), 64'd3);
    tick();
    check("b_logic_en", 64'({logic_en, test_active}), 64'b11);
    check("b_err_count_hold", 64'(err_count), 64'd3);
    repeat (5) tick();
    check("b_func_after", 64'({test_active, fault}), 64'b00);

    // Stuck fault on test vector 1001, cured by reconfiguration
    rst_n = 1'b0; enable = 1'b0; func_valid = 1'b0; mode = 2;
    tick(); rst_n = 1'b1; enable = 1'b1; func_valid = 1'b1; set_op(5);
    tick();
    repeat (8) tick();
    check("c_test", 64'(test_active), 64'd1);
    repeat (3) tick();
    check("c_no_pulse_yet", 64'(err_pulse), 64'd0);
    tick();
    check("c_pulse", 64'({err_pulse, err_count}), {55'd0, 1'b1, 8'd1});
    tick();
    check("c_reconfig", 64'({test_active, func_ready, logic_en}), 64'b000);
    tick();
    check("c_retest", 64'({test_active, logic_en}), 64'b11);
    repeat (5) tick();
    check("c_func", 64'({func_ready, test_active, fault}), 64'b100);
    check("c_err_count", 64'(err_count), 64'd1);

    // Reset during TEST cycle 2 drops the in-flight failing check
    mode = 4;
    repeat (8) tick();
    tick(); tick();
    check("e_pre", 64'({test_active, logic_en, err_pulse}), 64'b110);
    rst_n = 1'b0; enable = 1'b0;
    #1;
    check("e_async_outs", 64'({func_ready, test_active, logic_en, err_pulse, fault}), 64'd0);
    check("e_async_chk", w_chk64, 64'd0);
    check("e_async_cnt", 64'(err_count), 64'd0);
    tick();
    check("e_no_pulse", 64'(err_pulse), 64'd0);
    rst_n = 1'b1; mode = 0;
    tick();
    check("e_idle", 64'({func_ready, test_active}), 64'b00);
    check("e_idle_chk", w_chk64, 64'd0);
    enable = 1'b1; set_op(9);
    tick();
    check("e_func", 64'({func_ready, err_count}), {55'd0, 1'b1, 8'd0});

    // func_valid held across TEST: not consumed until FUNC resumes
    repeat (8) tick();
    set_op(10);
    for (int t = 0; t < 5; t++) begin
      check("f_ready_low", 64'({func_ready, test_active}), 64'b01);
      if (t < 4) tick();
    end
    tick();
    check("f_ready_back", 64'(func_ready), 64'd1);
    check("f_unconsumed", w_chk64, vecw(4'b1010));
    tick();
    check("f_consumed", w_chk64, opw(10));
    enable = 1'b0;
    tick();
    check("f_idle", 64'({func_ready, test_active}), 64'b00);
    check("f_idle_chk", w_chk64, 64'd0);

    // Persistent all-0 response -> RECONFIG, failed retest -> FAULT
    rst_n = 1'b0; func_valid = 1'b0; mode = 3;
    tick(); rst_n = 1'b1; enable = 1'b1; func_valid = 1'b1; set_op(12);
    tick();
    repeat (3) tick();
    tick();
    check("d_reconfig", 64'({test_active, func_ready, logic_en}), 64'b000);
    tick();
    check("d_retest", 64'({test_active, logic_en}), 64'b11);
    repeat (5) tick();
    check("d_fault", 64'({fault, test_active, func_ready}), 64'b100);
    check("d_fault_chk", w_chk64, 64'd0);
    check("d_err_count", 64'(err_count), 64'd8);
    enable = 1'b0; tick();
    enable = 1'b1; tick(); tick();
    check("d_fault_sticky", 64'({fault, func_ready, err_pulse}), 64'b100);
    check("d_fault_chk_hold", w_chk64, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
